// File: rtl/conv1d_pkg.sv
// ----------------------------------------------------------------------------
// conv1d_pkg
//   Shared types and helpers for the first-conv 1-D window reader.
//   - state_t    : run-control FSM encoding
//   - PAD        : 'same'-padding depth for the default 3-tap kernel
//   - pad_of     : 'same'-padding depth for an arbitrary odd kernel
//   - win_count  : number of windows a run of len samples produces
// ----------------------------------------------------------------------------
package conv1d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int KERNEL_DEFAULT = 3;
    localparam int PAD            = (KERNEL_DEFAULT - 1) / 2;

    // Zero samples added on each side of the data in 'same' mode.
    function automatic int pad_of(input int kernel);
        return (kernel - 1) / 2;
    endfunction

    // 'same' mode emits one window per sample; 'valid' mode only where the
    // kernel fits entirely inside the data.
    function automatic int win_count(input int len, input int kernel, input bit pad_en);
        if (pad_en) begin
            return len;
        end
        return (len >= kernel) ? (len - kernel + 1) : 0;
    endfunction

endpackage

// File: rtl/conv1d_rd_fifo.sv
// ----------------------------------------------------------------------------
// conv1d_rd_fifo
//   First-word-fall-through buffer for RAM return data. Push and pop may
//   happen in the same cycle. The occupancy count is registered so the read
//   scheduler can use it as a credit without a combinational path from pop.
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   push, push_data   write one word
//   pop               consume the head word (only when count != 0)
//   pop_data          head word, valid whenever count != 0
//   count             current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module conv1d_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state is assigned with <= so every register
            // samples the pre-edge values, independent of statement order.
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; its contents are only observed
    // behind count, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count == CW'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(pop && (count == '0)));

endmodule

// File: rtl/conv1d_window_reader.sv
// ----------------------------------------------------------------------------
// conv1d_window_reader
//   Read stage of the first-conv 1-D sample RAM. On start it streams len
//   samples from base_addr through the 1-cycle-latency RAM read port, forms
//   KERNEL-tap stride-1 sliding windows and hands them to the MAC array over
//   a valid/ready interface.
//
//   Build option: define ZERO_PAD_EN for 'same' padding ((KERNEL-1)/2 zero
//   samples before and after the data, one window per sample; KERNEL must be
//   odd). Undefined: 'valid' convolution, len-KERNEL+1 windows.
//
// Ports
//   clk, reset       clock, asynchronous active-low reset
//   start            one-cycle run request (accepted in IDLE and FIN)
//   base_addr, len   run parameters, captured on an accepted start
//   en_r, addr_r     RAM read request; addresses wrap modulo 2**ADDR_WIDTH
//   dat_read         RAM read data, valid the cycle after en_r
//   win_data         window, tap 0 (oldest sample) in the LSBs
//   win_valid/ready  window handshake; win_last marks the final window
//   busy             run in progress (cycle after start through done)
//   done             one-cycle end-of-run pulse
// ----------------------------------------------------------------------------
import conv1d_pkg::*;

module conv1d_window_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int D_WIDTH    = 15,
    parameter int KERNEL     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [ADDR_WIDTH:0]        len,
    output logic                       en_r,
    output logic [ADDR_WIDTH-1:0]      addr_r,
    input  logic [D_WIDTH-1:0]         dat_read,
    output logic [KERNEL*D_WIDTH-1:0]  win_data,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic                       win_last,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam int PAD_N = PAD_EN ? pad_of(KERNEL) : 0;

    // Shift counter spans len plus both pads, so it is two bits wider than
    // the address.
    localparam logic [AW:0]   RD_ONE = (AW+1)'(1);
    localparam logic [AW+1:0] SC_ONE = (AW+2)'(1);
    localparam logic [AW+1:0] K_W    = (AW+2)'(KERNEL);
    localparam logic [AW+1:0] PAD2_W = (AW+2)'(2 * PAD_N);

    if (KERNEL < 2) begin : g_bad_kernel
        $error("conv1d_window_reader: KERNEL must be >= 2");
    end
    if (FIFO_DEPTH < 3) begin : g_bad_depth
        $error("conv1d_window_reader: FIFO_DEPTH must be >= 3");
    end
`ifdef ZERO_PAD_EN
    if ((KERNEL % 2) == 0) begin : g_even_kernel
        $error("conv1d_window_reader: ZERO_PAD_EN requires an odd KERNEL");
    end
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                           state;
    state_t                           state_nxt;
    logic [AW-1:0]                    base_q;
    logic [AW:0]                      len_q;
    logic [AW:0]                      rd_idx;
    logic [AW+1:0]                    total_q;
    logic [AW+1:0]                    shift_cnt;
    logic                             has_work_q;
    logic                             outstanding;
    logic [KERNEL-1:0][D_WIDTH-1:0]   taps;

    // ------------------------------------------------------------------
    // Return-data buffer
    // ------------------------------------------------------------------
    logic [CW-1:0]      fifo_count;
    logic [D_WIDTH-1:0] fifo_dout;
    logic               pop;

    conv1d_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (D_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (outstanding),
        .push_data (dat_read),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    logic               start_ok;
    logic               credit_ok;
    logic               issue;
    logic               fire;
    logic               do_shift;
    logic               src_ok;
    logic [D_WIDTH-1:0] sample;

    // FIN accepts a new start so back-to-back runs lose no cycle.
    assign start_ok = start && ((state == IDLE) || (state == FIN));

    // A read is only issued when its return is guaranteed a FIFO slot.
    assign credit_ok = (int'(fifo_count) + int'(outstanding)) < FIFO_DEPTH;
    assign issue     = (state == RUN) && has_work_q && (rd_idx < len_q) && credit_ok;
    assign fire      = win_valid && win_ready;

`ifdef ZERO_PAD_EN
    logic in_pad;
    assign in_pad = (shift_cnt < PAD2_W / 2) || (shift_cnt >= (PAD2_W / 2) + {1'b0, len_q});
    assign src_ok = in_pad || (fifo_count != '0);
    assign sample = in_pad ? '0 : fifo_dout;
    assign pop    = do_shift && !in_pad;
`else
    assign src_ok = (fifo_count != '0);
    assign sample = fifo_dout;
    assign pop    = do_shift;
`endif

    // Shift only when the output slot is free or is being drained this cycle,
    // which keeps win_data stable under back-pressure.
    assign do_shift = ((state == RUN) || (state == FLUSH)) && (shift_cnt < total_q)
                      && src_ok && (!win_valid || win_ready);

    assign en_r     = issue;
    assign addr_r   = issue ? (base_q + rd_idx[AW-1:0]) : '0;
    assign win_data = taps;
    assign busy     = (state != IDLE);
    assign done     = (state == FIN);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case means every path drives
        // state_nxt, so no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN: begin
                if (!has_work_q) begin
                    state_nxt = FIN;
                end else if (issue && ((rd_idx + RD_ONE) == len_q)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH:   if (fire && win_last) state_nxt = FIN;
            FIN:     state_nxt = start_ok ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            rd_idx      <= '0;
            total_q     <= '0;
            shift_cnt   <= '0;
            has_work_q  <= 1'b0;
            outstanding <= 1'b0;
            taps        <= '0;
            win_valid   <= 1'b0;
            win_last    <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= issue;
            if (start_ok) begin
                base_q     <= base_addr;
                len_q      <= len;
                rd_idx     <= '0;
                total_q    <= {1'b0, len} + PAD2_W;
                shift_cnt  <= '0;
                has_work_q <= win_count(int'(len), KERNEL, PAD_EN) > 0;
                taps       <= '0;
                win_valid  <= 1'b0;
                win_last   <= 1'b0;
            end else begin
                if (issue) rd_idx <= rd_idx + RD_ONE;
                if (do_shift) begin
                    taps      <= {sample, taps[KERNEL-1:1]};
                    shift_cnt <= shift_cnt + SC_ONE;
                    win_valid <= (shift_cnt + SC_ONE) >= K_W;
                    win_last  <= (shift_cnt + SC_ONE) == total_q;
                end else if (fire) begin
                    win_valid <= 1'b0;
                    win_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv1d_window_reader.sv
// ----------------------------------------------------------------------------
// tb_conv1d_window_reader
//   Scoreboard bench for conv1d_window_reader. A RAM model answers reads one
//   cycle after en_r; expected windows are built from the same RAM contents
//   when a run is launched and compared as the DUT hands windows out.
// ----------------------------------------------------------------------------
module tb_conv1d_window_reader;

    localparam int AW = 10;
    localparam int DW = 15;
    localparam int K  = 3;
    localparam int FD = 4;
`ifdef ZERO_PAD_EN
    localparam int PADT = (K - 1) / 2;
`else
    localparam int PADT = 0;
`endif

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              start     = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       len       = '0;
    logic              en_r;
    logic [AW-1:0]     addr_r;
    logic [DW-1:0]     dat_read  = '0;
    logic [K*DW-1:0]   win_data;
    logic              win_valid;
    logic              win_ready = 1'b1;
    logic              win_last;
    logic              busy;
    logic              done;

    typedef struct {
        logic [K*DW-1:0] data;
        logic            last;
    } win_t;

    win_t            sb[$];
    int              addr_log[$];
    logic [DW-1:0]   ram [1024];

    int n_tests    = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int ph         = 0;
    int ready_mode = 0;
    int en_cnt     = 0;
    int win_seen   = 0;
    int first_v    = -1;
    int last_v     = -1;
    int done_cnt   = 0;
    int done_cyc   = -1;
    int start_cyc  = 0;
    logic            stall_prev = 1'b0;
    logic [K*DW-1:0] prev_data  = '0;

    conv1d_window_reader #(
        .ADDR_WIDTH (AW),
        .D_WIDTH    (DW),
        .KERNEL     (K),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .en_r      (en_r),
        .addr_r    (addr_r),
        .dat_read  (dat_read),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_last  (win_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = DW'(i + 1);
    end

    // RAM model with 1-cycle read latency, plus the cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en_r) dat_read <= ram[addr_r];
    end

    // Consumer ready: always high, or the 1,0,0,1 repeating pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ph++;
            win_ready = (ready_mode == 0) || ((ph % 4) == 0) || ((ph % 4) == 3);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Builds the sample stream (with pads in 'same' mode) and queues windows.
    task automatic push_expected(input int b, input int l, output int nwin);
        logic [DW-1:0] s[$];
        win_t          w;
        for (int i = 0; i < PADT; i++) s.push_back('0);
        for (int i = 0; i < l; i++)    s.push_back(ram[(b + i) % 1024]);
        for (int i = 0; i < PADT; i++) s.push_back('0);
        nwin = (s.size() >= K) ? (s.size() - K + 1) : 0;
        for (int j = 0; j < nwin; j++) begin
            w.data = '0;
            for (int t = 0; t < K; t++) w.data[t*DW +: DW] = s[j + t];
            w.last = (j == nwin - 1);
            sb.push_back(w);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (en_r) begin
                addr_log.push_back(int'(addr_r));
                en_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stall_prev) begin
                check("hold_valid", win_valid, 1'b1);
                check("hold_data", win_data, prev_data);
            end
            if (win_valid && first_v < 0) first_v = cyc;
            if (win_valid && win_ready) begin
                win_seen++;
                last_v = cyc;
                check("window_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    win_t w;
                    w = sb.pop_front();
                    check("win_data", win_data, w.data);
                    check("win_last", win_last, w.last);
                end
            end
            stall_prev = win_valid && !win_ready;
            prev_data  = win_data;
        end
    end

    task automatic do_run(input int b, input int l, input int mode, output int nwin);
        int d0;
        ready_mode = mode;
        push_expected(b, l, nwin);
        addr_log.delete();
        en_cnt   = 0;
        win_seen = 0;
        first_v  = -1;
        last_v   = -1;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(b);
        len       = (AW+1)'(l);
        start_cyc = cyc;
        d0        = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
        check("done_pulse", done_cnt - d0, 1);
        check("sb_drained", sb.size(), 0);
        check("win_count", win_seen, nwin);
        sb.delete();
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_en_r"},      en_r,      1'b0);
        check({pfx, "_addr_r"},    addr_r,    '0);
        check({pfx, "_win_valid"}, win_valid, 1'b0);
        check({pfx, "_win_last"},  win_last,  1'b0);
        check({pfx, "_win_data"},  win_data,  '0);
        check({pfx, "_busy"},      busy,      1'b0);
        check({pfx, "_done"},      done,      1'b0);
    endtask

    initial begin
        int n;
        int d0;

        // Reset state
        @(negedge clk);
        check_outputs_zero("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // T1: base 0, len 8, ready high
        do_run(0, 8, 0, n);
        check("t1_first_latency_ok", (first_v - start_cyc) <= (K + 4), 1'b1);
        check("t1_one_per_cycle", last_v - first_v, n - 1);

        // T2: same run, ready toggling 1,0,0,1
        do_run(0, 8, 1, n);

        // T3: address wrap from 1022
        do_run(1022, 5, 0, n);
        check("t3_nreads", addr_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < addr_log.size()) check("t3_addr", addr_log[i], (1022 + i) % 1024);
        end

`ifndef ZERO_PAD_EN
        // T4a: len shorter than the kernel
        do_run(0, 2, 0, n);
        check("t4_len2_no_reads", en_cnt, 0);
        check("t4_len2_no_valid", first_v, -1);
        check("t4_len2_done_at_2", done_cyc - start_cyc, 2);
`endif
        // T4b: len 0
        do_run(0, 0, 0, n);
        check("t4_len0_no_reads", en_cnt, 0);
        check("t4_len0_no_valid", first_v, -1);
        check("t4_len0_done_at_2", done_cyc - start_cyc, 2);

        // T5: reset during the third window of a len 8 run
        ready_mode = 0;
        win_seen   = 0;
        push_expected(0, 8, n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = '0;
        len       = (AW+1)'(8);
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 200 && win_seen < 2; i++) @(posedge clk);
        check("t5_reached_window3", win_seen >= 2, 1'b1);
        #1 reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("t5_rst");
        @(posedge clk);
        #1 reset = 1'b1;
        d0 = done_cnt;
        repeat (8) @(posedge clk);
        check("t5_no_done_abort", done_cnt, d0);
        @(negedge clk);
        check("t5_idle_after_abort", busy, 1'b0);
        sb.delete();
        do_run(0, 4, 0, n);

`ifdef ZERO_PAD_EN
        // T6: 'same' padding, len 4
        do_run(0, 4, 0, n);
        check("t6_nwin", win_seen, 4);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
